// File: rtl/fetch_sequencer_if.sv
// Control bus between the fetch sequencer, the instruction ROM/IR and the register datapath.
interface fetch_sequencer_if;
  logic       run;
  logic [8:0] irline;
  logic       gzero;
  logic [4:0] addr;
  logic       iren;
  logic [9:0] muxline;
  logic [7:0] rin;
  logic       ain;
  logic       gin;
  logic       addsub;
  logic       done;
  logic       halted;

  modport master (
    input  run, irline, gzero,
    output addr, iren, muxline, rin, ain, gin, addsub, done, halted
  );

  modport slave (
    output run, irline, gzero,
    input  addr, iren, muxline, rin, ain, gin, addsub, done, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer for a simple 8-register processor with a 5-bit PC.
// Optional mvnz instruction (opcode 100) is enabled by defining FETCH_SEQUENCER_MVNZ_EN.
module fetch_sequencer (
  input  logic                clk_i,
  input  logic                reset_i,
  fetch_sequencer_if.master   bus
);

  localparam int unsigned PC_W  = 5;
  localparam int unsigned REG_N = 8;
  localparam int unsigned MUX_W = 10;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef FETCH_SEQUENCER_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_T1,
    S_T2,
    S_T3,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  state_e            resume_c;
  logic [PC_W-1:0]   pc_q, pc_d;

  logic [2:0]        op;
  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [REG_N-1:0]  rx_oh;
  logic [REG_N-1:0]  ry_oh;

  logic              iren_c;
  logic [MUX_W-1:0]  mux_c;
  logic [REG_N-1:0]  rin_c;
  logic              ain_c;
  logic              gin_c;
  logic              addsub_c;
  logic              done_c;
  logic              halted_c;

  assign op    = bus.irline[8:6];
  assign rx    = bus.irline[5:3];
  assign ry    = bus.irline[2:0];
  assign rx_oh = REG_N'(1) << rx;
  assign ry_oh = REG_N'(1) << ry;

`ifdef FETCH_SEQUENCER_MVNZ_EN
`else
  logic unused_gzero;
  assign unused_gzero = bus.gzero;
`endif

  // State and PC register; reset wins over everything, including HALT.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and Moore output decode; RUN only matters in IDLE and on DONE cycles.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    resume_c = bus.run ? S_F1 : S_IDLE;
    iren_c   = 1'b0;
    mux_c    = '0;
    rin_c    = '0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    addsub_c = 1'b0;
    done_c   = 1'b0;
    halted_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_F1;
      end
      S_F1: begin
        state_d = S_F2;
      end
      S_F2: begin
        iren_c  = 1'b1;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_T1;
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            mux_c   = {2'b00, ry_oh};
            rin_c   = rx_oh;
            done_c  = 1'b1;
            state_d = resume_c;
          end
          OP_MVI: begin
            state_d = S_T2;
          end
          OP_ADD, OP_SUB: begin
            mux_c   = {2'b00, rx_oh};
            ain_c   = 1'b1;
            state_d = S_T2;
          end
`ifdef FETCH_SEQUENCER_MVNZ_EN
          OP_MVNZ: begin
            if (!bus.gzero) begin
              mux_c = {2'b00, ry_oh};
              rin_c = rx_oh;
            end
            done_c  = 1'b1;
            state_d = resume_c;
          end
`endif
          OP_HALT: begin
            done_c  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            done_c  = 1'b1;
            state_d = resume_c;
          end
        endcase
      end
      S_T2: begin
        case (op)
          OP_MVI: begin
            mux_c   = MUX_W'(1) << 9;
            rin_c   = rx_oh;
            pc_d    = pc_q + PC_W'(1);
            done_c  = 1'b1;
            state_d = resume_c;
          end
          OP_ADD, OP_SUB: begin
            mux_c    = {2'b00, ry_oh};
            gin_c    = 1'b1;
            addsub_c = (op == OP_SUB);
            state_d  = S_T3;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
      S_T3: begin
        mux_c   = MUX_W'(1) << 8;
        rin_c   = rx_oh;
        done_c  = 1'b1;
        state_d = resume_c;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.addr    = pc_q;
  assign bus.iren    = iren_c;
  assign bus.muxline = mux_c;
  assign bus.rin     = rin_c;
  assign bus.ain     = ain_c;
  assign bus.gin     = gin_c;
  assign bus.addsub  = addsub_c;
  assign bus.done    = done_c;
  assign bus.halted  = halted_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a synchronous-read ROM and external IR model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [32];
  logic [8:0] rom_q = '0;
  logic [8:0] ir    = '0;

  always @(posedge clk) begin
    rom_q <= rom[bus.addr];
    if (bus.iren) ir <= rom_q;
  end

  assign bus.irline = ir;

  logic [28:0] obs;
  assign obs = {bus.addr, bus.iren, bus.muxline, bus.rin, bus.ain,
                bus.gin, bus.addsub, bus.done, bus.halted};

  function automatic logic [28:0] v(input logic [4:0] a, input logic ie,
                                    input logic [9:0] m, input logic [7:0] r,
                                    input logic ai, input logic gi, input logic as,
                                    input logic dn, input logic ht);
    return {a, ie, m, r, ai, gi, as, dn, ht};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [28:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.run   = 1'b0;
    bus.gzero = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 9'o000;
    rom[0] = 9'o013;  // mv R1,R3
    rom[1] = 9'o150;  // mvi R5
    rom[2] = 9'o123;  // immediate
    rom[3] = 9'o307;  // sub R0,R7
    rom[4] = 9'o222;  // add R2,R2

    tick(); tick();
    chk("reset_idle", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    bus.run = 1'b1;
    tick();
    chk("reset_dominates_run", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // mv R1,R3
    tick(); chk("mv_f1", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mv_f2", v(5'd0, 1, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mv_t1", v(5'd1, 0, 10'h008, 8'h02, 0, 0, 0, 1, 0));
    // mvi R5, back-to-back
    tick(); chk("mvi_f1", v(5'd1, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mvi_f2", v(5'd1, 1, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mvi_t1", v(5'd2, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mvi_t2", v(5'd2, 0, 10'h200, 8'h20, 0, 0, 0, 1, 0));
    // sub R0,R7
    tick(); chk("sub_f1", v(5'd3, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("sub_f2", v(5'd3, 1, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("sub_t1", v(5'd4, 0, 10'h001, 8'h00, 1, 0, 0, 0, 0));
    tick(); chk("sub_t2", v(5'd4, 0, 10'h080, 8'h00, 0, 1, 1, 0, 0));
    tick(); chk("sub_t3", v(5'd4, 0, 10'h100, 8'h01, 0, 0, 0, 1, 0));
    // add R2,R2 aborted by reset in T2
    tick(); chk("add_f1", v(5'd4, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("add_f2", v(5'd4, 1, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("add_t1", v(5'd5, 0, 10'h004, 8'h00, 1, 0, 0, 0, 0));
    tick(); chk("add_t2", v(5'd5, 0, 10'h004, 8'h00, 0, 1, 0, 0, 0));
    reset = 1'b1;
    tick(); chk("mid_reset", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    reset   = 1'b0;
    bus.run = 1'b0;
    tick(); chk("idle_hold", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));

    // mvnz R1,R2 with GZERO=1 then GZERO=0, then reserved opcode 101
    rom[0] = 9'o412;
    rom[1] = 9'o412;
    rom[2] = 9'o512;
    bus.gzero = 1'b1;
    bus.run   = 1'b1;
    tick(); tick(); tick();
    chk("mvnz_gz1", v(5'd1, 0, 10'h000, 8'h00, 0, 0, 0, 1, 0));
    bus.run = 1'b0;
    tick(); chk("done_to_idle", v(5'd1, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("idle_stays", v(5'd1, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    bus.gzero = 1'b0;
    bus.run   = 1'b1;
    tick(); tick(); tick();
`ifdef FETCH_SEQUENCER_MVNZ_EN
    chk("mvnz_gz0", v(5'd2, 0, 10'h004, 8'h02, 0, 0, 0, 1, 0));
`else
    chk("mvnz_gz0", v(5'd2, 0, 10'h000, 8'h00, 0, 0, 0, 1, 0));
`endif
    tick(); tick(); tick();
    chk("reserved_101", v(5'd3, 0, 10'h000, 8'h00, 0, 0, 0, 1, 0));
    bus.run = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;

    // PC wrap: mv R0,R0 at 0..30, mvi R6 at 31 with operand at 0, halt at 1
    for (int i = 0; i < 31; i++) rom[i] = 9'o000;
    rom[31] = 9'o160;
    bus.run = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick(); tick(); tick();
      chk("wrap_mv", v(5'(i + 1), 0, 10'h001, 8'h01, 0, 0, 0, 1, 0));
      if (i == 1) rom[1] = 9'o700;
    end
    tick(); chk("mvi31_f1", v(5'd31, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mvi31_f2", v(5'd31, 1, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mvi31_t1", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); chk("mvi31_t2", v(5'd0, 0, 10'h200, 8'h40, 0, 0, 0, 1, 0));
    tick(); chk("wrap_f1", v(5'd1, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    tick(); tick();
    chk("halt_t1", v(5'd2, 0, 10'h000, 8'h00, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      bus.run = (i % 2 == 1);
      tick();
      chk("halted_hold", v(5'd2, 0, 10'h000, 8'h00, 0, 0, 0, 0, 1));
    end
    reset = 1'b1;
    tick(); chk("halt_reset", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));
    reset   = 1'b0;
    bus.run = 1'b0;
    tick(); chk("post_halt_idle", v(5'd0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
